// File: rtl/rx_preamble_sync.sv
// OOK receive front end: threshold calibration, bit timing recovery, preamble hunt, payload.
// Optional: define RX_PAYLOAD_RESYNC_EN to let line edges re-align the bit phase during PAYLOAD.
module rx_preamble_sync #(
    parameter int unsigned        WIDTH      = 10,
    parameter int unsigned        SPB        = 4,
    parameter int unsigned        PRE_LEN    = 8,
    parameter logic [PRE_LEN-1:0] PREAMBLE   = 8'hD5,
    parameter int unsigned        FRAME_BITS = 16,
    parameter int unsigned        CAL_LEN    = 32,
    parameter int unsigned        MIN_SWING  = 64,
    parameter int unsigned        TIMEOUT    = 1024
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_sample,
    output logic             o_busy,
    output logic             o_sync,
    output logic             o_bit,
    output logic             o_bit_valid,
    output logic             o_done,
    output logic             o_timeout,
    output logic [WIDTH-1:0] o_threshold
);

    localparam int unsigned PH_W  = $clog2(SPB + 1);
    localparam int unsigned CAL_W = $clog2(CAL_LEN + 1);
    localparam int unsigned BC_W  = $clog2(FRAME_BITS + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPB - 1);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(SPB / 2);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_LEN - 1);
    localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(FRAME_BITS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCal,
        StHunt,
        StPayload,
        StDone
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_min;
    logic [WIDTH-1:0]   r_max;
    logic [CAL_W-1:0]   r_cal_cnt;
    logic [WIDTH-1:0]   r_threshold;
    logic               r_s_prev;
    logic [PH_W-1:0]    r_ph;
    logic [PRE_LEN-1:0] r_shift;
    logic [BC_W-1:0]    r_bit_cnt;
    logic [TO_W-1:0]    r_smp_cnt;
    logic               r_busy;
    logic               r_sync;
    logic               r_bit;
    logic               r_bit_valid;
    logic               r_done;
    logic               r_timeout;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_min_nxt;
    logic [WIDTH-1:0]   w_max_nxt;
    logic [CAL_W-1:0]   w_cal_cnt_nxt;
    logic [WIDTH-1:0]   w_threshold_nxt;
    logic [PH_W-1:0]    w_ph_nxt;
    logic [PRE_LEN-1:0] w_shift_nxt;
    logic [BC_W-1:0]    w_bit_cnt_nxt;
    logic [TO_W-1:0]    w_smp_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_sync_nxt;
    logic               w_bit_nxt;
    logic               w_bit_valid_nxt;
    logic               w_done_nxt;
    logic               w_timeout_nxt;

    logic               w_s;
    logic               w_edge;
    logic [PH_W-1:0]    w_ph_inc;
    logic [PH_W-1:0]    w_ph_track;
    logic               w_decide_track;
    logic [PH_W-1:0]    w_ph_pay;
    logic               w_decide_pay;
    logic [WIDTH-1:0]   w_min_upd;
    logic [WIDTH-1:0]   w_max_upd;
    logic [WIDTH-1:0]   w_swing;
    logic               w_swing_ok;
    logic [WIDTH:0]     w_thr_sum;
    logic               w_unused_lsb;

    assign w_s = (i_sample >= r_threshold);

    // The edge sample itself is phase 0, so the following sample is phase 1.
    assign w_edge         = (w_s != r_s_prev);
    assign w_ph_inc       = (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;
    assign w_ph_track     = w_edge ? PH_ONE : w_ph_inc;
    assign w_decide_track = !w_edge && (r_ph == PH_MID);

`ifdef RX_PAYLOAD_RESYNC_EN
    assign w_ph_pay     = w_ph_track;
    assign w_decide_pay = w_decide_track;
`else
    assign w_ph_pay     = w_ph_inc;
    assign w_decide_pay = (r_ph == PH_MID);
`endif

    assign w_min_upd  = (i_sample < r_min) ? i_sample : r_min;
    assign w_max_upd  = (i_sample > r_max) ? i_sample : r_max;
    assign w_swing    = w_max_upd - w_min_upd;
    assign w_swing_ok = (w_swing >= WIDTH'(MIN_SWING));
    // Midpoint needs the carry bit; the shifted-out LSB is dropped.
    assign w_thr_sum    = {1'b0, w_max_upd} + {1'b0, w_min_upd};
    assign w_unused_lsb = w_thr_sum[0];

    assign w_busy_nxt = (w_state_nxt == StCal) || (w_state_nxt == StHunt) ||
                        (w_state_nxt == StPayload);

    always_comb begin
        w_state_nxt     = r_state;
        w_min_nxt       = r_min;
        w_max_nxt       = r_max;
        w_cal_cnt_nxt   = r_cal_cnt;
        w_threshold_nxt = r_threshold;
        w_ph_nxt        = r_ph;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_smp_cnt_nxt   = r_smp_cnt;
        w_sync_nxt      = 1'b0;
        w_bit_nxt       = r_bit;
        w_bit_valid_nxt = 1'b0;
        w_done_nxt      = r_done;
        w_timeout_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt   = StCal;
                    w_min_nxt     = '1;
                    w_max_nxt     = '0;
                    w_cal_cnt_nxt = '0;
                end
            end
            StCal: begin
                w_min_nxt     = w_min_upd;
                w_max_nxt     = w_max_upd;
                w_cal_cnt_nxt = r_cal_cnt + 1'b1;
                if (r_cal_cnt == CAL_LAST) begin
                    w_min_nxt     = '1;
                    w_max_nxt     = '0;
                    w_cal_cnt_nxt = '0;
                    if (w_swing_ok) begin
                        w_threshold_nxt = w_thr_sum[WIDTH:1];
                        w_state_nxt     = StHunt;
                        w_ph_nxt        = '0;
                        w_shift_nxt     = '0;
                        w_smp_cnt_nxt   = '0;
                    end
                end
            end
            StHunt: begin
                w_ph_nxt      = w_ph_track;
                w_smp_cnt_nxt = r_smp_cnt + 1'b1;
                if (w_decide_track) begin
                    w_shift_nxt = {r_shift[PRE_LEN-2:0], w_s};
                end
                // Match is checked first so it wins over a coincident timeout.
                if (r_shift == PREAMBLE) begin
                    w_sync_nxt    = 1'b1;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = StPayload;
                end else if (r_smp_cnt == TO_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = StIdle;
                end
            end
            StPayload: begin
                w_ph_nxt = w_ph_pay;
                if (w_decide_pay) begin
                    w_bit_nxt       = w_s;
                    w_bit_valid_nxt = 1'b1;
                    w_bit_cnt_nxt   = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = StDone;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            StDone: begin
                if (i_start) begin
                    w_state_nxt   = StCal;
                    w_done_nxt    = 1'b0;
                    w_min_nxt     = '1;
                    w_max_nxt     = '0;
                    w_cal_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_min       <= '1;
            r_max       <= '0;
            r_cal_cnt   <= '0;
            r_threshold <= '0;
            r_s_prev    <= 1'b0;
            r_ph        <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_smp_cnt   <= '0;
            r_busy      <= 1'b0;
            r_sync      <= 1'b0;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_min       <= w_min_nxt;
            r_max       <= w_max_nxt;
            r_cal_cnt   <= w_cal_cnt_nxt;
            r_threshold <= w_threshold_nxt;
            r_s_prev    <= w_s;
            r_ph        <= w_ph_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_smp_cnt   <= w_smp_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_sync      <= w_sync_nxt;
            r_bit       <= w_bit_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_sync      = r_sync;
    assign o_bit       = r_bit;
    assign o_bit_valid = r_bit_valid;
    assign o_done      = r_done;
    assign o_timeout   = r_timeout;
    assign o_threshold = r_threshold;

endmodule
